// File: rtl/argon_mem_pkg.sv
// Shared types for the Argon memory controller: access mask encodings,
// controller FSM states and the address alignment helpers.
package argon_mem_pkg;

  typedef enum logic [2:0] {
    RDMASK_NONE = 3'd0,
    RDMASK_BU   = 3'd1,
    RDMASK_B    = 3'd2,
    RDMASK_HU   = 3'd3,
    RDMASK_H    = 3'd4,
    RDMASK_W    = 3'd5
  } rd_mask_e;

  typedef enum logic [1:0] {
    WRMASK_NONE = 2'd0,
    WRMASK_B    = 2'd1,
    WRMASK_H    = 2'd2,
    WRMASK_W    = 2'd3
  } wr_mask_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } mem_state_e;

  localparam int WS_MAX = 15;

  // True when the byte offset is illegal for the access size.
  function automatic logic misaligned(input logic [1:0] lo, input logic is_half,
                                      input logic is_word);
    return (is_half && lo[0]) || (is_word && (lo != 2'b00));
  endfunction

  // Offending low bits forced to zero for the access size.
  function automatic logic [1:0] align_lo(input logic [1:0] lo, input logic is_half,
                                          input logic is_word);
    if (is_word)      return 2'b00;
    else if (is_half) return {lo[1], 1'b0};
    else              return lo;
  endfunction

endpackage

// File: rtl/argon_mem_lane.sv
// Byte-lane steering: little-endian store replication with byte enables,
// and load lane extraction with zero/sign extension.
module argon_mem_lane
  import argon_mem_pkg::*;
(
  input  logic [1:0]  i_st_lo,
  input  wr_mask_e    i_wr_mask,
  input  logic [31:0] i_wr_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_lo,
  input  rd_mask_e    i_rd_mask,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;

  // Store steering: replicate the right-aligned data into every lane.
  always_comb begin
    o_be    = 4'h0;
    o_wdata = 32'h0;
    case (i_wr_mask)
      WRMASK_B: begin
        o_be    = 4'b0001 << i_st_lo;
        o_wdata = {4{i_wr_data[7:0]}};
      end
      WRMASK_H: begin
        o_be    = i_st_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wr_data[15:0]}};
      end
      WRMASK_W: begin
        o_be    = 4'hF;
        o_wdata = i_wr_data;
      end
      default: begin
        o_be    = 4'h0;
        o_wdata = 32'h0;
      end
    endcase
  end

  assign w_byte_sh = i_rdata >> {i_ld_lo, 3'b000};
  assign w_half_sh = i_rdata >> {i_ld_lo[1], 4'b0000};

  // Load extraction: shift the addressed lane down, then extend.
  always_comb begin
    o_ld_data = 32'h0;
    case (i_rd_mask)
      RDMASK_BU: o_ld_data = {24'h0, w_byte_sh[7:0]};
      RDMASK_B:  o_ld_data = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      RDMASK_HU: o_ld_data = {16'h0, w_half_sh[15:0]};
      RDMASK_H:  o_ld_data = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      RDMASK_W:  o_ld_data = i_rdata;
      default:   o_ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/argon_mem_ctrl.sv
// Argon memory controller: one CPU access at a time onto a single-port
// synchronous SRAM with byte enables and WAIT_STATES extra access cycles.
// Build option ARGON_MEM_MISALIGN_TRAP_EN: misaligned accesses skip the SRAM
// and respond with o_resp_err=1; otherwise they are silently aligned.
// Handshake: a request is taken on a clock edge where i_req_valid and
// o_req_ready are both high; o_resp_valid pulses for exactly one cycle.
module argon_mem_ctrl
  import argon_mem_pkg::*;
#(
  parameter int AW          = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic          sys_clk,
  input  logic          i_reset,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_wr_data,
  input  logic [2:0]    i_rd_mask,
  input  logic [1:0]    i_wr_mask,
  output logic          o_resp_valid,
  output logic [31:0]   o_rd_data,
  output logic          o_resp_err,
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [3:0]    o_ram_be,
  output logic [31:0]   o_ram_wdata,
  input  logic [31:0]   i_ram_rdata,
  output logic [1:0]    o_dbg_state
);

  localparam logic [3:0] WS_INIT = WAIT_STATES[3:0];

  mem_state_e  r_state;
  logic [3:0]  r_wait;
  logic [1:0]  r_lo;
  rd_mask_e    r_rd;

  wr_mask_e    w_wr;
  rd_mask_e    w_rd;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_is_mem;
  logic        w_trap;
  logic [1:0]  w_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;
  logic        w_unused_addr;

  // Request decode: a store wins over a load; read codes 6-7 mean no access.
  assign w_wr      = wr_mask_e'(i_wr_mask);
  assign w_rd      = ((w_wr != WRMASK_NONE) || (i_rd_mask > 3'd5)) ? RDMASK_NONE
                                                                   : rd_mask_e'(i_rd_mask);
  assign w_is_half = (w_wr == WRMASK_H) || (w_rd == RDMASK_H) || (w_rd == RDMASK_HU);
  assign w_is_word = (w_wr == WRMASK_W) || (w_rd == RDMASK_W);
  assign w_is_mem  = (w_wr != WRMASK_NONE) || (w_rd != RDMASK_NONE);
  assign w_lo      = align_lo(i_addr[1:0], w_is_half, w_is_word);

`ifdef ARGON_MEM_MISALIGN_TRAP_EN
  assign w_trap = misaligned(i_addr[1:0], w_is_half, w_is_word);
`else
  assign w_trap = 1'b0;
`endif

  // Address bits above the SRAM word range wrap and are intentionally dropped.
  assign w_unused_addr = ^i_addr[31:AW+2];
  assign o_dbg_state   = r_state;

  argon_mem_lane u_lane (
    .i_st_lo   (w_lo),
    .i_wr_mask (w_wr),
    .i_wr_data (i_wr_data),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .i_ld_lo   (r_lo),
    .i_rd_mask (r_rd),
    .i_rdata   (i_ram_rdata),
    .o_ld_data (w_ld_data)
  );

  // Controller FSM with all outputs registered.
  always_ff @(posedge sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_wait       <= 4'd0;
      r_lo         <= 2'b00;
      r_rd         <= RDMASK_NONE;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_rd_data    <= 32'h0;
      o_resp_err   <= 1'b0;
      o_ram_en     <= 1'b0;
      o_ram_we     <= 1'b0;
      o_ram_addr   <= '0;
      o_ram_be     <= 4'h0;
      o_ram_wdata  <= 32'h0;
    end else begin
      o_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            r_lo        <= w_lo;
            r_rd        <= w_rd;
            r_wait      <= WS_INIT;
            o_ram_addr  <= i_addr[AW+1:2];
            o_ram_be    <= (w_wr == WRMASK_NONE) ? 4'hF : w_be;
            o_ram_wdata <= w_wdata;
            if (w_is_mem && !w_trap) begin
              r_state  <= ST_ACCESS;
              o_ram_en <= 1'b1;
              o_ram_we <= (w_wr != WRMASK_NONE);
            end else begin
              r_state      <= ST_RESP;
              o_resp_valid <= 1'b1;
              o_resp_err   <= w_trap;
              o_rd_data    <= 32'h0;
            end
          end
        end
        ST_ACCESS: begin
          if (r_wait == 4'd0) begin
            o_ram_en <= 1'b0;
            o_ram_we <= 1'b0;
            if (r_rd != RDMASK_NONE) begin
              r_state <= ST_CAPTURE;
            end else begin
              r_state      <= ST_RESP;
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b0;
              o_rd_data    <= 32'h0;
            end
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        ST_CAPTURE: begin
          r_state      <= ST_RESP;
          o_resp_valid <= 1'b1;
          o_resp_err   <= 1'b0;
          o_rd_data    <= w_ld_data;
        end
        default: begin
          r_state     <= ST_IDLE;
          o_req_ready <= 1'b1;
          o_rd_data   <= 32'h0;
          o_resp_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argon_mem_ctrl.sv
// Bench for argon_mem_ctrl: two instances (WAIT_STATES 0 and 3), each with
// its own SRAM model; sel chooses which instance the driver talks to.
module tb_argon_mem_ctrl;
  import argon_mem_pkg::*;

  localparam int AW = 12;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  logic i_reset;

  // ---------------- shared stimulus ----------------
  logic        sel;
  logic        req_valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  rd_mask;
  logic [1:0]  wr_mask;

  // ---------------- per-instance signals ----------------
  logic          rdy0, rv0, err0, en0, we0, rdy3, rv3, err3, en3, we3;
  logic [31:0]   rd0, wd0, rdat0, rd3, wd3, rdat3;
  logic [AW-1:0] ad0, ad3;
  logic [3:0]    be0, be3;
  logic [1:0]    st0, st3;

  logic          m_ready, m_resp_valid, m_err, m_en, m_we;
  logic [31:0]   m_rd, m_wdata;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_be;

  assign m_ready      = sel ? rdy3 : rdy0;
  assign m_resp_valid = sel ? rv3  : rv0;
  assign m_err        = sel ? err3 : err0;
  assign m_en         = sel ? en3  : en0;
  assign m_we         = sel ? we3  : we0;
  assign m_rd         = sel ? rd3  : rd0;
  assign m_wdata      = sel ? wd3  : wd0;
  assign m_addr       = sel ? ad3  : ad0;
  assign m_be         = sel ? be3  : be0;

  argon_mem_ctrl #(.AW(AW), .WAIT_STATES(0)) u_dut0 (
    .sys_clk(sys_clk), .i_reset(i_reset), .i_req_valid(req_valid & ~sel),
    .o_req_ready(rdy0), .i_addr(addr), .i_wr_data(wdata), .i_rd_mask(rd_mask),
    .i_wr_mask(wr_mask), .o_resp_valid(rv0), .o_rd_data(rd0), .o_resp_err(err0),
    .o_ram_en(en0), .o_ram_we(we0), .o_ram_addr(ad0), .o_ram_be(be0),
    .o_ram_wdata(wd0), .i_ram_rdata(rdat0), .o_dbg_state(st0)
  );

  argon_mem_ctrl #(.AW(AW), .WAIT_STATES(3)) u_dut3 (
    .sys_clk(sys_clk), .i_reset(i_reset), .i_req_valid(req_valid & sel),
    .o_req_ready(rdy3), .i_addr(addr), .i_wr_data(wdata), .i_rd_mask(rd_mask),
    .i_wr_mask(wr_mask), .o_resp_valid(rv3), .o_rd_data(rd3), .o_resp_err(err3),
    .o_ram_en(en3), .o_ram_we(we3), .o_ram_addr(ad3), .o_ram_be(be3),
    .o_ram_wdata(wd3), .i_ram_rdata(rdat3), .o_dbg_state(st3)
  );

  // ---------------- SRAM models ----------------
  logic [31:0] mem0 [0:(1<<AW)-1];
  logic [31:0] mem3 [0:(1<<AW)-1];

  always @(posedge sys_clk) begin
    if (en0) begin
      for (int b = 0; b < 4; b++)
        if (we0 && be0[b]) mem0[ad0][8*b +: 8] <= wd0[8*b +: 8];
      rdat0 <= mem0[ad0];
    end
  end

  always @(posedge sys_clk) begin
    if (en3) begin
      for (int b = 0; b < 4; b++)
        if (we3 && be3[b]) mem3[ad3][8*b +: 8] <= wd3[8*b +: 8];
      rdat3 <= mem3[ad3];
    end
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  int          res_lat, res_en;
  logic        res_we, res_err;
  logic [3:0]  res_be;
  logic [31:0] res_wdata, res_rd;
  logic [AW-1:0] res_addr;

  // One request; res_lat counts edges from acceptance (edge 1) to the response.
  task automatic access(input logic [1:0] wm, input logic [2:0] rm,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    wr_mask = wm; rd_mask = rm; addr = a; wdata = d; req_valid = 1'b1;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    res_lat = 1; res_en = 0; res_we = 1'b0; res_be = 4'h0; res_wdata = 32'h0; res_addr = '0;
    while (!m_resp_valid && res_lat < 40) begin
      if (m_en) begin
        res_en++; res_we = m_we; res_be = m_be; res_wdata = m_wdata; res_addr = m_addr;
      end
      @(posedge sys_clk); #1;
      res_lat++;
    end
    check("resp_seen", 32'(m_resp_valid), 32'd1);
    res_rd  = m_rd;
    res_err = m_err;
    @(posedge sys_clk); #1;
  endtask

  int r1, r2, first_ready, pulses;

  initial begin
    sel = 1'b0; req_valid = 1'b0; addr = 32'h0; wdata = 32'h0;
    rd_mask = 3'd0; wr_mask = 2'd0;
    i_reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_ready0", 32'(rdy0), 32'd1);
    check("rst_ready3", 32'(rdy3), 32'd1);
    check("rst_en", 32'({en0, en3, we0, we3}), 32'd0);
    check("rst_resp", 32'({rv0, rv3, err0, err3}), 32'd0);
    check("rst_rd", rd0 | rd3, 32'd0);
    @(negedge sys_clk);
    i_reset = 1'b0;

    // ---- WAIT_STATES = 0 ----
    access(2'd3, 3'd0, 32'h10, 32'hDEADBEEF);
    check("sw_be", 32'(res_be), 32'hF);
    check("sw_addr", 32'(res_addr), 32'd4);
    check("sw_we", 32'(res_we), 32'd1);
    check("sw_wdata", res_wdata, 32'hDEADBEEF);
    check("sw_lat", 32'(res_lat), 32'd2);

    access(2'd0, 3'd5, 32'h10, 32'h0);
    check("lw_data", res_rd, 32'hDEADBEEF);
    check("lw_lat", 32'(res_lat), 32'd3);
    check("lw_err", 32'(res_err), 32'd0);

    access(2'd0, 3'd5, 32'h11, 32'h0);
`ifdef ARGON_MEM_MISALIGN_TRAP_EN
    check("mis_en", 32'(res_en), 32'd0);
    check("mis_err", 32'(res_err), 32'd1);
    check("mis_data", res_rd, 32'h0);
    check("mis_lat", 32'(res_lat), 32'd1);
`else
    check("mis_en", 32'(res_en), 32'd1);
    check("mis_err", 32'(res_err), 32'd0);
    check("mis_data", res_rd, 32'hDEADBEEF);
    check("mis_addr", 32'(res_addr), 32'd4);
`endif

    access(2'd1, 3'd0, 32'h13, 32'h80);
    check("sb_be", 32'(res_be), 32'h8);
    check("sb_wdata", res_wdata, 32'h80808080);
    access(2'd0, 3'd2, 32'h13, 32'h0);
    check("lb_data", res_rd, 32'hFFFFFF80);
    access(2'd0, 3'd1, 32'h13, 32'h0);
    check("lbu_data", res_rd, 32'h00000080);

    access(2'd2, 3'd0, 32'h22, 32'h8001);
    check("sh_be", 32'(res_be), 32'hC);
    check("sh_wdata", res_wdata, 32'h80018001);
    access(2'd0, 3'd4, 32'h22, 32'h0);
    check("lh_data", res_rd, 32'hFFFF8001);
    access(2'd0, 3'd3, 32'h22, 32'h0);
    check("lhu_data", res_rd, 32'h00008001);

    access(2'd0, 3'd0, 32'h10, 32'h0);
    check("nop_lat", 32'(res_lat), 32'd1);
    check("nop_en", 32'(res_en), 32'd0);
    check("nop_data", res_rd, 32'h0);

    access(2'd0, 3'd6, 32'h10, 32'h0);
    check("rm6_lat", 32'(res_lat), 32'd1);
    check("rm6_en", 32'(res_en), 32'd0);

    access(2'd3, 3'd5, 32'h30, 32'h12345678);
    check("prec_data", res_rd, 32'h0);
    check("prec_we", 32'(res_we), 32'd1);
    check("prec_lat", 32'(res_lat), 32'd2);

    // ---- WAIT_STATES = 3 ----
    sel = 1'b1;
    access(2'd3, 3'd0, 32'h40, 32'hCAFEF00D);
    check("ws3_sw_lat", 32'(res_lat), 32'd5);
    check("ws3_sw_en", 32'(res_en), 32'd4);
    access(2'd0, 3'd5, 32'h40, 32'h0);
    check("ws3_lw_data", res_rd, 32'hCAFEF00D);
    check("ws3_lw_en", 32'(res_en), 32'd4);
    check("ws3_lw_lat", 32'(res_lat), 32'd6);

    // Back-to-back: valid held high across two loads.
    exp_q.push_back(32'hCAFEF00D);
    exp_q.push_back(32'hCAFEF00D);
    r1 = -1; r2 = -1; first_ready = -1;
    @(negedge sys_clk);
    wr_mask = 2'd0; rd_mask = 3'd5; addr = 32'h40; req_valid = 1'b1;
    @(posedge sys_clk); #1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge sys_clk); #1;
      if (m_resp_valid) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
        if (exp_q.size() > 0) check("b2b_data", m_rd, exp_q.pop_front());
        else check("b2b_extra_resp", 32'd1, 32'd0);
      end
      if (m_ready && first_ready < 0) first_ready = i;
      if (i == 12) req_valid = 1'b0;
    end
    check("b2b_resp1", 32'(r1), 32'd5);
    check("b2b_ready", 32'(first_ready), 32'd6);
    check("b2b_resp2", 32'(r2), 32'd12);
    check("b2b_left", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a held store.
    @(negedge sys_clk);
    wr_mask = 2'd3; rd_mask = 3'd0; addr = 32'h50; wdata = 32'h11111111; req_valid = 1'b1;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    check("mid_en", 32'(m_en), 32'd1);
    @(posedge sys_clk); #3;
    i_reset = 1'b1;
    #1;
    check("mid_rst_en", 32'(m_en), 32'd0);
    check("mid_rst_ready", 32'(m_ready), 32'd1);
    check("mid_rst_state", 32'(st3), 32'(ST_IDLE));
    @(negedge sys_clk);
    i_reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk); #1;
      if (m_resp_valid) pulses++;
    end
    check("mid_rst_pulses", 32'(pulses), 32'd0);
    check("mid_rst_idle_en", 32'(m_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
